lif_timestep_scheduler: RTL
===========================

Name: lif_timestep_scheduler

Overview:
- Time-multiplexes one shared LIF update datapath across N_NEURONS virtual neurons, replacing N parallel neuron instances in the spiking network.
- Neuron membrane states live in a register array. On each start, the block sequences one timestep: every neuron is updated in index order, one per cycle.
- The aggregated spike vector is then published with a done pulse. It sits between the input current source and the downstream summing/output-neuron stage.

Parameters:
- N_NEURONS, 8, number of virtual neurons; must be at least 2.
- WIDTH, 8, bit width of currents, state, beta and threshold.
- REFRAC_STEPS, 2, refractory length in timesteps; used only when REFRACTORY_EN is defined.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset: synchronous, active-low.
- start, input, 1, request one timestep; sampled only in IDLE.
- current_in, input, N_NEURONS*WIDTH, per-neuron input current; neuron i uses bits [i*WIDTH +: WIDTH]; captured on the accepting edge.
- beta, input, WIDTH, global decay factor, captured with current_in.
- threshold, input, WIDTH, global firing threshold, captured with current_in.
- busy, output, 1, high while in UPDATE or DONE.
- done, output, 1, one-cycle pulse: timestep complete, spike_vec valid.
- spike_vec, output, N_NEURONS, spikes of the last completed timestep; bit i is neuron i.
- state_sel, input, clog2(N_NEURONS), debug read index.
- state_rd, output, WIDTH, combinational read of state[state_sel]; out-of-range index returns 0.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM returns to IDLE; idx=0.
  - All states = 0; spike_vec = 0; busy = 0; done = 0; refractory counters = 0.
  - Reset applies in any state, including mid-UPDATE. The partial timestep is discarded, not resumed.
- FSM states: IDLE -> UPDATE -> DONE -> IDLE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: latch current_in, beta and threshold; set idx=0; go to UPDATE.
- UPDATE: each edge processes neuron idx:
  - decayed = (state[idx] * beta) >> WIDTH, computed with 2*WIDTH-bit intermediate.
  - sum = decayed + cur[idx], computed WIDTH+1 bits wide, then saturated to 2^WIDTH-1.
  - If sum >= threshold: spike_next[idx]=1 and state[idx] <= sum - threshold (subtractive reset).
  - Else: spike_next[idx]=0 and state[idx] <= sum.
  - threshold=0 means every neuron spikes each timestep and state is unchanged from sum.
  - After idx=N_NEURONS-1: go to DONE. Otherwise idx increments.
- DONE:
  - spike_vec <= spike_next, registered on the edge entering DONE. done=1 for exactly the DONE cycle.
  - Next edge: return to IDLE.
- Latency: done is high N_NEURONS cycles after the accepting edge.
- Throughput: with start held high, timesteps start every N_NEURONS+2 cycles.
- start while busy is ignored, not queued.
- Input changes after the accepting edge have no effect on the current timestep.
- spike_vec holds its value between done pulses.
- state_rd may show partially updated states during UPDATE.

Optional Feature:
- Macro: REFRACTORY_EN.
- Defined:
  - Each neuron has a counter of width clog2(REFRAC_STEPS+1).
  - On spike, the counter loads REFRAC_STEPS.
  - While the counter is nonzero, the neuron's update forces state=0 and spike=0, and the counter decrements by 1 per timestep.
- Undefined: no counters exist; neurons are never refractory.

Decomposition:
- Shared package lif_pkg holds:
  - FSM state enum (IDLE, UPDATE, DONE).
  - Default WIDTH and N_NEURONS constants.
  - A saturate-add helper function.
- Sub-module lif_update_unit: purely combinational.
  - Inputs: state, current, beta, threshold (and refractory count when enabled).
  - Outputs: next_state, spike (and next refractory count when enabled).
  - Reusable by the output-neuron stage.

Test Plan:
- Reset, then idle 5 cycles -> spike_vec=0, busy=0, done=0, state_rd=0 for all indices.
- Neuron0 current=100, others 0, beta=255, threshold=150. Expected:
  - Timestep 1: spike_vec[0]=0, state0=100.
  - Timestep 2: decayed 99 + 100 = 199, spike_vec[0]=1, state0=49.
- Saturation: drive state0 to 200 (beta=255, threshold=255), then current0=255 -> 199+255 clamps to 255 -> spike_vec[0]=1, state0=0.
- Handshake: pulse start, then pulse again 3 cycles later -> the second pulse is ignored. done goes high exactly 8 cycles after acceptance, for 1 cycle. start held high -> done every 10 cycles.
- Reset asserted while idx=3 in UPDATE -> next cycle busy=0, no done pulse, all states 0, spike_vec 0.
- REFRACTORY_EN, REFRAC_STEPS=2, current0=255, threshold=10:
  - Spikes at timesteps 1 and 4; timesteps 2 and 3 show spike=0 and state0=0.
  - Without the macro: spikes every timestep.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron datapath.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DONE
  } lif_state_e;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_N_NEURONS = 8;

  // Unsigned add clamped to the all-ones value of a w-bit word (w <= 31).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_timestep_scheduler_if.sv
// Request/result bundle between the current source, the scheduler and its debug reader.
interface lif_timestep_scheduler_if #(
  parameter int N_NEURONS = lif_pkg::DEF_N_NEURONS,
  parameter int WIDTH     = lif_pkg::DEF_WIDTH
);
  localparam int SEL_W = $clog2(N_NEURONS);

  logic                       start;
  logic [N_NEURONS*WIDTH-1:0] current_in;
  logic [WIDTH-1:0]           beta;
  logic [WIDTH-1:0]           threshold;
  logic                       busy;
  logic                       done;
  logic [N_NEURONS-1:0]       spike_vec;
  logic [SEL_W-1:0]           state_sel;
  logic [WIDTH-1:0]           state_rd;

  modport master (
    output start, current_in, beta, threshold, state_sel,
    input  busy, done, spike_vec, state_rd
  );

  modport slave (
    input  start, current_in, beta, threshold, state_sel,
    output busy, done, spike_vec, state_rd
  );

endinterface

// File: rtl/lif_update_unit.sv
// Combinational single-neuron LIF step: decay, saturating integrate, subtractive-reset fire.
// REFRACTORY_EN adds a per-neuron refractory countdown that suppresses integration and firing.
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
`ifdef REFRACTORY_EN
  , parameter int CNT_W = 2,
  parameter int REFRAC_STEPS = 2
`endif
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] current,
  input  logic [WIDTH-1:0] beta,
  input  logic [WIDTH-1:0] threshold,
`ifdef REFRACTORY_EN
  input  logic [CNT_W-1:0] refrac,
  output logic [CNT_W-1:0] next_refrac,
`endif
  output logic [WIDTH-1:0] next_state,
  output logic             spike
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   decayed;
  logic [WIDTH-1:0]   sum_sat;
  logic               fire;

  // beta acts as a fraction of 2^WIDTH, so beta = all-ones is "almost no leak".
  assign prod    = {{WIDTH{1'b0}}, state} * {{WIDTH{1'b0}}, beta};
  assign decayed = WIDTH'(prod >> WIDTH);
  assign sum_sat = WIDTH'(sat_add(32'(decayed), 32'(current), WIDTH));
  assign fire    = (sum_sat >= threshold);

  always_comb begin
    next_state = fire ? (sum_sat - threshold) : sum_sat;
    spike      = fire;
`ifdef REFRACTORY_EN
    next_refrac = fire ? CNT_W'(REFRAC_STEPS) : '0;
    if (refrac != '0) begin
      next_state  = '0;
      spike       = 1'b0;
      next_refrac = refrac - CNT_W'(1);
    end
`endif
  end

endmodule

// File: rtl/lif_timestep_scheduler.sv
// Sequences one shared LIF update unit over N_NEURONS stored states, one neuron per cycle;
// done pulses N_NEURONS cycles after start is accepted, start while busy is dropped. Option: REFRACTORY_EN.
module lif_timestep_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS    = DEF_N_NEURONS,
  parameter int WIDTH        = DEF_WIDTH,
  parameter int REFRAC_STEPS = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  lif_timestep_scheduler_if.slave bus
);

  localparam int               IDX_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  typedef struct packed {
    logic [WIDTH-1:0] beta;
    logic [WIDTH-1:0] threshold;
  } cfg_t;

  lif_state_e                 fsm;
  logic [IDX_W-1:0]           idx;
  logic [WIDTH-1:0]           states [N_NEURONS];
  logic [N_NEURONS*WIDTH-1:0] cur_q;
  cfg_t                       cfg_q;
  logic [N_NEURONS-1:0]       spike_next;
  logic [N_NEURONS-1:0]       spike_vec_q;
  logic                       busy_q;
  logic                       done_q;

  logic [WIDTH-1:0]           cur_sel;
  logic [WIDTH-1:0]           upd_state;
  logic                       upd_spike;
  logic [N_NEURONS-1:0]       spike_merged;

  assign cur_sel = cur_q[int'(idx)*WIDTH +: WIDTH];

`ifdef REFRACTORY_EN
  localparam int CNT_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  logic [CNT_W-1:0] refrac [N_NEURONS];
  logic [CNT_W-1:0] upd_refrac;

  lif_update_unit #(
    .WIDTH        (WIDTH),
    .CNT_W        (CNT_W),
    .REFRAC_STEPS (REFRAC_STEPS)
  ) u_upd (
    .state       (states[idx]),
    .current     (cur_sel),
    .beta        (cfg_q.beta),
    .threshold   (cfg_q.threshold),
    .refrac      (refrac[idx]),
    .next_refrac (upd_refrac),
    .next_state  (upd_state),
    .spike       (upd_spike)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) refrac[i] <= '0;
    end else if (fsm == UPDATE) begin
      refrac[idx] <= upd_refrac;
    end
  end
`else
  logic [31:0] unused_refrac_steps;
  assign unused_refrac_steps = 32'(REFRAC_STEPS);

  lif_update_unit #(
    .WIDTH (WIDTH)
  ) u_upd (
    .state      (states[idx]),
    .current    (cur_sel),
    .beta       (cfg_q.beta),
    .threshold  (cfg_q.threshold),
    .next_state (upd_state),
    .spike      (upd_spike)
  );
`endif

  // The last neuron's spike is folded in directly so spike_vec is valid in the DONE cycle.
  always_comb begin
    spike_merged      = spike_next;
    spike_merged[idx] = upd_spike;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      idx         <= '0;
      cur_q       <= '0;
      cfg_q       <= '0;
      spike_next  <= '0;
      spike_vec_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) states[i] <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            cur_q           <= bus.current_in;
            cfg_q.beta      <= bus.beta;
            cfg_q.threshold <= bus.threshold;
            idx             <= '0;
            busy_q          <= 1'b1;
            fsm             <= UPDATE;
          end
        end
        UPDATE: begin
          states[idx]     <= upd_state;
          spike_next[idx] <= upd_spike;
          if (idx == LAST_IDX) begin
            spike_vec_q <= spike_merged;
            done_q      <= 1'b1;
            fsm         <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          fsm    <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.spike_vec = spike_vec_q;

  always_comb begin
    bus.state_rd = '0;
    if (int'(bus.state_sel) < N_NEURONS) bus.state_rd = states[bus.state_sel];
  end

endmodule
